// File: rtl/wb_sequencer_pkg.sv
// Shared codes for the write-back sequencer: class, RegDest, wb_src and state encodings,
// plus the per-class write-select table used by the sequencer.
package wb_sequencer_pkg;

  typedef enum logic [2:0] {
    WB_NONE  = 3'd0,
    WB_RTYPE = 3'd1,
    WB_ITYPE = 3'd2,
    WB_LOAD  = 3'd3,
    WB_JAL   = 3'd4,
    WB_PUSH  = 3'd5,
    WB_POP   = 3'd6,
    WB_XCHG  = 3'd7
  } wbClass_t;

  typedef enum logic [2:0] {
    RD_RT = 3'd0,
    RD_RS = 3'd1,
    RD_SP = 3'd2,
    RD_RA = 3'd3,
    RD_RD = 3'd4
  } regDest_t;

  typedef enum logic [2:0] {
    SRC_ALU   = 3'd0,
    SRC_MDR   = 3'd1,
    SRC_PC    = 3'd2,
    SRC_REGB  = 3'd3,
    SRC_REGA  = 3'd4,
    SRC_SPADJ = 3'd5
  } wbSrc_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_WRITE1   = 3'd2,
    ST_WRITE2   = 3'd3,
    ST_DONE     = 3'd4
  } wbState_t;

  typedef struct packed {
    regDest_t dest;
    wbSrc_t   src;
  } wbSel_t;

  // Destination/source for the first or second write of a class; only POP and XCHG have a second.
  function automatic wbSel_t writeSel(input wbClass_t cls, input logic second);
    wbSel_t sel;
    sel.dest = RD_RT;
    sel.src  = SRC_ALU;
    case (cls)
      WB_RTYPE: begin sel.dest = RD_RD; sel.src = SRC_ALU;   end
      WB_LOAD:  begin sel.dest = RD_RT; sel.src = SRC_MDR;   end
      WB_JAL:   begin sel.dest = RD_RA; sel.src = SRC_PC;    end
      WB_PUSH:  begin sel.dest = RD_SP; sel.src = SRC_SPADJ; end
      WB_POP: begin
        if (second) begin sel.dest = RD_SP; sel.src = SRC_SPADJ; end
        else        begin sel.dest = RD_RT; sel.src = SRC_MDR;   end
      end
      WB_XCHG: begin
        if (second) begin sel.dest = RD_RT; sel.src = SRC_REGA; end
        else        begin sel.dest = RD_RS; sel.src = SRC_REGB; end
      end
      default: begin sel.dest = RD_RT; sel.src = SRC_ALU; end
    endcase
    return sel;
  endfunction

  function automatic logic needsMem(input wbClass_t cls);
    return (cls == WB_LOAD) || (cls == WB_POP);
  endfunction

  function automatic logic isTwoWrite(input wbClass_t cls);
    return (cls == WB_POP) || (cls == WB_XCHG);
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Handshake between the main control FSM (master) and the write-back sequencer (slave).
interface wb_sequencer_if;
  logic       i_start;
  logic [2:0] i_wbClass;
  logic       i_abort;
  logic [2:0] o_regDest;
  logic [2:0] o_wbSrc;
  logic       o_regWrite;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_start, i_wbClass, i_abort,
    output o_regDest, o_wbSrc, o_regWrite, o_busy, o_done
  );

  modport master (
    output i_start, i_wbClass, i_abort,
    input  o_regDest, o_wbSrc, o_regWrite, o_busy, o_done
  );
endinterface

// File: rtl/wb_sequencer.sv
// Multicycle write-back controller: sequences memory wait, one or two register writes
// and a completion pulse per accepted instruction class.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic           clk,
  input  logic           rst,
  wb_sequencer_if.slave  bus
);

  localparam logic       USE_WAIT  = (MEM_WAIT > 0);
  localparam logic [3:0] WAIT_INIT = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  wbState_t   r_state;
  wbClass_t   r_class;
  logic [3:0] r_waitCnt;
  regDest_t   r_regDest;
  wbSrc_t     r_wbSrc;
  logic       r_writeEn;
  logic       r_busy;
  logic       r_done;

  wbClass_t   w_reqClass;
  wbSel_t     w_reqSel;
  wbSel_t     w_firstSel;
  wbSel_t     w_secondSel;

  assign w_reqClass  = wbClass_t'(bus.i_wbClass);
  assign w_reqSel    = writeSel(w_reqClass, 1'b0);
  assign w_firstSel  = writeSel(r_class, 1'b0);
  assign w_secondSel = writeSel(r_class, 1'b1);

  // Outputs are registered alongside the state so they change only on state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_class   <= WB_NONE;
      r_waitCnt <= 4'd0;
      r_regDest <= RD_RT;
      r_wbSrc   <= SRC_ALU;
      r_writeEn <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && bus.i_abort) begin
        r_state   <= ST_IDLE;
        r_waitCnt <= 4'd0;
        r_writeEn <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.i_start && !bus.i_abort) begin
              r_class <= w_reqClass;
              r_busy  <= 1'b1;
              if (w_reqClass == WB_NONE) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else if (needsMem(w_reqClass) && USE_WAIT) begin
                r_state   <= ST_WAIT_MEM;
                r_waitCnt <= WAIT_INIT;
              end else begin
                r_state   <= ST_WRITE1;
                r_writeEn <= 1'b1;
                r_regDest <= w_reqSel.dest;
                r_wbSrc   <= w_reqSel.src;
              end
            end
          end
          ST_WAIT_MEM: begin
            if (r_waitCnt == 4'd0) begin
              r_state   <= ST_WRITE1;
              r_writeEn <= 1'b1;
              r_regDest <= w_firstSel.dest;
              r_wbSrc   <= w_firstSel.src;
            end else begin
              r_waitCnt <= r_waitCnt - 4'd1;
            end
          end
          ST_WRITE1: begin
            if (isTwoWrite(r_class)) begin
              r_state   <= ST_WRITE2;
              r_regDest <= w_secondSel.dest;
              r_wbSrc   <= w_secondSel.src;
            end else begin
              r_state   <= ST_DONE;
              r_writeEn <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          ST_WRITE2: begin
            r_state   <= ST_DONE;
            r_writeEn <= 1'b0;
            r_done    <= 1'b1;
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_writeEn <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // A flush must suppress the strobe in the very cycle it arrives.
  assign bus.o_regWrite = r_writeEn & ~bus.i_abort;
  assign bus.o_regDest  = r_regDest;
  assign bus.o_wbSrc    = r_wbSrc;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the expected output timeline.
module tb_wb_sequencer;

  localparam int MW = 2;

  logic clk = 1'b0;
  logic rst;

  wb_sequencer_if bus();

  wb_sequencer #(.MEM_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic [2:0] d;
    logic [2:0] s;
    logic       b;
    logic       dn;
  } exp_t;

  // Per-class write targets, indexed by class code; entries for NONE are never used.
  logic [2:0] firstDest  [0:7] = '{3'd0, 3'd4, 3'd0, 3'd0, 3'd3, 3'd2, 3'd0, 3'd1};
  logic [2:0] firstSrc   [0:7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd5, 3'd1, 3'd3};
  logic [2:0] secondDest [0:7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0};
  logic [2:0] secondSrc  [0:7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd4};

  exp_t       q[$];
  logic [2:0] curD;
  logic [2:0] curS;
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  bit         modelCheck  = 1'b0;

  // An accepted instruction becomes a list of future cycles: memory waits, writes, then done.
  task automatic modelAccept(input logic [2:0] c);
    logic [2:0] holdD;
    logic [2:0] holdS;
    int         waits;
    holdD = curD;
    holdS = curS;
    if (c == 3'd0) begin
      q.push_back('{1'b0, holdD, holdS, 1'b1, 1'b1});
    end else begin
      waits = ((c == 3'd3) || (c == 3'd6)) ? MW : 0;
      for (int i = 0; i < waits; i++)
        q.push_back('{1'b0, holdD, holdS, 1'b1, 1'b0});
      holdD = firstDest[c];
      holdS = firstSrc[c];
      q.push_back('{1'b1, holdD, holdS, 1'b1, 1'b0});
      if ((c == 3'd6) || (c == 3'd7)) begin
        holdD = secondDest[c];
        holdS = secondSrc[c];
        q.push_back('{1'b1, holdD, holdS, 1'b1, 1'b0});
      end
      q.push_back('{1'b0, holdD, holdS, 1'b1, 1'b1});
    end
  endtask

  // Model advance: an empty timeline means idle, so only then can a start be taken.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      curD = 3'd0;
      curS = 3'd0;
    end else begin
      if (q.size() != 0) begin
        if (bus.i_abort) q.delete();
        else void'(q.pop_front());
      end else if (bus.i_start && !bus.i_abort) begin
        modelAccept(bus.i_wbClass);
      end
      if (q.size() != 0) begin
        curD = q[0].d;
        curS = q[0].s;
      end
      cyc++;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin : cmp
    exp_t e;
    logic ew;
    if (modelCheck) begin
      if (rst)                 e = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
      else if (q.size() == 0)  e = '{1'b0, curD, curS, 1'b0, 1'b0};
      else                     e = q[0];
      ew = e.w && !bus.i_abort && !rst;
      vectors++;
      if ({bus.o_regWrite, bus.o_regDest, bus.o_wbSrc, bus.o_busy, bus.o_done} !==
          {ew, e.d, e.s, e.b, e.dn}) begin
        miscompares++;
        $display("[TB] FAIL model cycle %0d: got W=%b D=%0d S=%0d busy=%b done=%b, expected W=%b D=%0d S=%0d busy=%b done=%b",
                 cyc, bus.o_regWrite, bus.o_regDest, bus.o_wbSrc, bus.o_busy, bus.o_done,
                 ew, e.d, e.s, e.b, e.dn);
      end
    end
  end

  task automatic applyStimulus(input logic s, input logic [2:0] c, input logic a);
    @(posedge clk);
    #1;
    bus.i_start   = s;
    bus.i_wbClass = c;
    bus.i_abort   = a;
  endtask

  task automatic checkOutput(input string name, input logic ew, input logic [2:0] ed,
                             input logic [2:0] es, input logic eb, input logic edn);
    vectors++;
    if ({bus.o_regWrite, bus.o_regDest, bus.o_wbSrc, bus.o_busy, bus.o_done} !==
        {ew, ed, es, eb, edn}) begin
      miscompares++;
      $display("[TB] FAIL %s: got W=%b D=%0d S=%0d busy=%b done=%b, expected W=%b D=%0d S=%0d busy=%b done=%b",
               name, bus.o_regWrite, bus.o_regDest, bus.o_wbSrc, bus.o_busy, bus.o_done,
               ew, ed, es, eb, edn);
    end
  endtask

  task automatic runCycle(input string name, input logic s, input logic [2:0] c, input logic a,
                          input logic ew, input logic [2:0] ed, input logic [2:0] es,
                          input logic eb, input logic edn);
    applyStimulus(s, c, a);
    @(negedge clk);
    checkOutput(name, ew, ed, es, eb, edn);
  endtask

  initial begin
    bus.i_start   = 1'b0;
    bus.i_wbClass = 3'd0;
    bus.i_abort   = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    checkOutput("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    modelCheck = 1'b1;

    // RTYPE: write at 1, done at 2
    runCycle("rtype c0", 1, 3'd1, 0, 0, 3'd0, 3'd0, 0, 0);
    runCycle("rtype c1", 0, 3'd0, 0, 1, 3'd4, 3'd0, 1, 0);
    runCycle("rtype c2", 0, 3'd0, 0, 0, 3'd4, 3'd0, 1, 1);
    runCycle("rtype c3", 0, 3'd0, 0, 0, 3'd4, 3'd0, 0, 0);

    // LOAD with two wait cycles
    runCycle("load c0", 1, 3'd3, 0, 0, 3'd4, 3'd0, 0, 0);
    runCycle("load c1", 0, 3'd0, 0, 0, 3'd4, 3'd0, 1, 0);
    runCycle("load c2", 0, 3'd0, 0, 0, 3'd4, 3'd0, 1, 0);
    runCycle("load c3", 0, 3'd0, 0, 1, 3'd0, 3'd1, 1, 0);
    runCycle("load c4", 0, 3'd0, 0, 0, 3'd0, 3'd1, 1, 1);
    runCycle("load c5", 0, 3'd0, 0, 0, 3'd0, 3'd1, 0, 0);

    // POP: waits then two writes
    runCycle("pop c0", 1, 3'd6, 0, 0, 3'd0, 3'd1, 0, 0);
    runCycle("pop c1", 0, 3'd0, 0, 0, 3'd0, 3'd1, 1, 0);
    runCycle("pop c2", 0, 3'd0, 0, 0, 3'd0, 3'd1, 1, 0);
    runCycle("pop c3", 0, 3'd0, 0, 1, 3'd0, 3'd1, 1, 0);
    runCycle("pop c4", 0, 3'd0, 0, 1, 3'd2, 3'd5, 1, 0);
    runCycle("pop c5", 0, 3'd0, 0, 0, 3'd2, 3'd5, 1, 1);
    runCycle("pop c6", 0, 3'd0, 0, 0, 3'd2, 3'd5, 0, 0);

    // XCHG: rs<-regB then rt<-regA
    runCycle("xchg c0", 1, 3'd7, 0, 0, 3'd2, 3'd5, 0, 0);
    runCycle("xchg c1", 0, 3'd0, 0, 1, 3'd1, 3'd3, 1, 0);
    runCycle("xchg c2", 0, 3'd0, 0, 1, 3'd0, 3'd4, 1, 0);
    runCycle("xchg c3", 0, 3'd0, 0, 0, 3'd0, 3'd4, 1, 1);
    runCycle("xchg c4", 0, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0);

    // JAL with a second start while busy, which must be dropped
    runCycle("jal c0", 1, 3'd4, 0, 0, 3'd0, 3'd4, 0, 0);
    runCycle("jal c1", 1, 3'd1, 0, 1, 3'd3, 3'd2, 1, 0);
    runCycle("jal c2", 0, 3'd0, 0, 0, 3'd3, 3'd2, 1, 1);
    runCycle("jal c3", 0, 3'd0, 0, 0, 3'd3, 3'd2, 0, 0);
    runCycle("jal c4", 0, 3'd0, 0, 0, 3'd3, 3'd2, 0, 0);

    // XCHG aborted in its second write
    runCycle("xabort c0", 1, 3'd7, 0, 0, 3'd3, 3'd2, 0, 0);
    runCycle("xabort c1", 0, 3'd0, 0, 1, 3'd1, 3'd3, 1, 0);
    runCycle("xabort c2", 0, 3'd0, 1, 0, 3'd0, 3'd4, 1, 0);
    runCycle("xabort c3", 0, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0);
    runCycle("xabort c4", 0, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0);

    // NONE: done at 1, no write
    runCycle("none c0", 1, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0);
    runCycle("none c1", 0, 3'd0, 0, 0, 3'd0, 3'd4, 1, 1);
    runCycle("none c2", 0, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0);

    // abort together with start in IDLE drops the start
    runCycle("abstart c0", 1, 3'd1, 1, 0, 3'd0, 3'd4, 0, 0);
    runCycle("abstart c1", 0, 3'd0, 0, 0, 3'd0, 3'd4, 0, 0);

    // ITYPE then PUSH back-to-back at the earliest idle cycle
    runCycle("itype c0", 1, 3'd2, 0, 0, 3'd0, 3'd4, 0, 0);
    runCycle("itype c1", 0, 3'd0, 0, 1, 3'd0, 3'd0, 1, 0);
    runCycle("itype c2", 0, 3'd0, 0, 0, 3'd0, 3'd0, 1, 1);
    runCycle("push c0",  1, 3'd5, 0, 0, 3'd0, 3'd0, 0, 0);
    runCycle("push c1",  0, 3'd0, 0, 1, 3'd2, 3'd5, 1, 0);
    runCycle("push c2",  0, 3'd0, 0, 0, 3'd2, 3'd5, 1, 1);
    runCycle("push c3",  0, 3'd0, 0, 0, 3'd2, 3'd5, 0, 0);

    // Reset asserted mid-cycle during POP's first write
    runCycle("rstpop c0", 1, 3'd6, 0, 0, 3'd2, 3'd5, 0, 0);
    runCycle("rstpop c1", 0, 3'd0, 0, 0, 3'd2, 3'd5, 1, 0);
    runCycle("rstpop c2", 0, 3'd0, 0, 0, 3'd2, 3'd5, 1, 0);
    runCycle("rstpop c3", 0, 3'd0, 0, 1, 3'd0, 3'd1, 1, 0);
    #2 rst = 1'b1;
    #1 checkOutput("rstpop async", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    runCycle("rstpop r0", 0, 3'd0, 0, 0, 3'd0, 3'd0, 0, 0);
    runCycle("rstpop r1", 0, 3'd0, 0, 0, 3'd0, 3'd0, 0, 0);
    runCycle("rstpop r2", 0, 3'd0, 0, 0, 3'd0, 3'd0, 0, 0);

    // Randomized traffic, checked only by the model comparison
    for (int n = 0; n < 2000; n++)
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) == 0));
    applyStimulus(1'b0, 3'd0, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    modelCheck = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Multicycle write-back controller for the register file destination path.
- Takes a decoded write-back class from the main control unit and produces the RegDest select (rt/rs/29/31/rd), the write-data source select and a one-cycle RegWrite strobe, with one or two writes per instruction.
- Handles load-memory wait cycles and the two-write instructions (pop, xchg).
- Sits between the control FSM and the register-destination mux, data mux and register bank.

Parameters:
- MEM_WAIT, 2, cycles between start and MDR valid for LOAD/POP (0..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- wb_class  input  3  000 NONE, 001 RTYPE, 010 ITYPE, 011 LOAD, 100 JAL, 101 PUSH, 110 POP, 111 XCHG
- abort  input  1  exception/flush; cancels the current sequence
- RegDest  output  3  000 rt, 001 rs, 010 $29, 011 $31, 100 rd
- wb_src  output  3  000 ALUOut, 001 MDR, 010 PC, 011 regB, 100 regA, 101 SP-adjust result
- RegWrite  output  1  register-bank write strobe
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset values, applied asynchronously: state IDLE, RegDest=000, wb_src=000, RegWrite=0, busy=0, done=0, wait counter=0, latched class=NONE.
- States: IDLE, WAIT_MEM, WRITE1, WRITE2, DONE.
- IDLE:
  - start=1 latches wb_class.
  - Next state is DONE for NONE.
  - Next state is WAIT_MEM for LOAD/POP when MEM_WAIT>0; with MEM_WAIT=0 it goes directly to WRITE1.
  - Next state is WRITE1 for all other classes.
  - start=0 keeps IDLE.
- WAIT_MEM:
  - The counter loads MEM_WAIT-1 on entry and decrements each cycle.
  - The block exits to WRITE1 on the cycle the counter is 0.
  - It stays exactly MEM_WAIT cycles.
- WRITE1, RegWrite=1, with RegDest and wb_src per class:
  - RTYPE: rd, ALUOut.
  - ITYPE: rt, ALUOut.
  - LOAD: rt, MDR.
  - JAL: $31, PC.
  - PUSH: $29, SP-adjust.
  - POP: rt, MDR.
  - XCHG: rs, regB.
- Transitions out of WRITE1: POP and XCHG go to WRITE2; all other classes go to DONE.
- WRITE2, RegWrite=1:
  - POP: $29, SP-adjust.
  - XCHG: rt, regA.
  - Next state is DONE.
- DONE: done=1 for one cycle, then IDLE. start is not accepted in DONE; the earliest accept is the IDLE cycle that follows.
- Output timing:
  - Outputs are Moore (decoded from state and latched class).
  - RegWrite is the exception: it is gated combinationally with !abort.
  - RegDest/wb_src are stable for the whole write cycle.
  - Outside the write states RegDest/wb_src hold their last value (000 after reset).
- Latency, with start accepted at cycle 0:
  - RTYPE: write at cycle 1, done at cycle 2.
  - LOAD (MEM_WAIT=2): waits at cycles 1-2, write at cycle 3, done at cycle 4.
  - POP (MEM_WAIT=2): writes at cycles 3 and 4, done at cycle 5.
  - NONE: done at cycle 1.
- start while busy=1 is ignored; nothing is queued.
- abort in any non-IDLE state:
  - RegWrite is forced to 0 in that same cycle.
  - The next state is IDLE, done is not pulsed, and the counter clears.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and the start is dropped.
- reset mid-sequence returns the block to IDLE immediately with all outputs at reset values, and no partial second write occurs.
- Exactly one RegWrite pulse per write state; never two consecutive strobes to the same destination within one instruction.

Decomposition:
- Shared package wb_pkg:
  - wb_class codes.
  - RegDest codes (RD_RT, RD_RS, RD_SP, RD_RA, RD_RD).
  - wb_src codes.
  - State encoding.
- No sub-module; the wait counter is inline. The existing RegDest mux stays a separate instance driven by RegDest.

Test Plan:
- Reset asserted mid-POP during WRITE1 -> outputs at reset values in the same cycle, state IDLE, no WRITE2 strobe after release.
- start with RTYPE -> RegWrite=1, RegDest=100, wb_src=000 at cycle 1; done=1 at cycle 2; busy high for cycles 1-2.
- start with LOAD, MEM_WAIT=2 -> RegWrite low at cycles 1-2; RegWrite=1, RegDest=000, wb_src=001 at cycle 3; done at cycle 4.
- start with POP -> cycle 3: RegDest=000, wb_src=001; cycle 4: RegDest=010, wb_src=101; done at cycle 5. XCHG -> cycle 1: RegDest=001, wb_src=011; cycle 2: RegDest=000, wb_src=100; done at cycle 3.
- JAL started, second start issued at cycle 1 -> single write with RegDest=011, wb_src=010; second start ignored; busy falls at cycle 3.
- XCHG with abort=1 in WRITE2 -> RegWrite=0 that cycle, IDLE next cycle, done never pulses; NONE class -> done at cycle 1 with no RegWrite.
